// File: rtl/display_7_pkg.sv
// Shared segment codes and the grade binary-to-BCD converter for the display_7 status panel.
package display_7_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-low segment codes, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Double dabble; values above 9999 clamp so the field never overflows four digits
    function automatic logic [15:0] bin16_to_bcd4(input logic [15:0] bin);
        logic [19:0] bcd;
        logic [15:0] sr;
        bcd = '0;
        sr  = bin;
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 5; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[18:0], sr[15]};
            sr  = {sr[14:0], 1'b0};
        end
        if (bin > 16'd9999) bcd = 20'h09999;
        return bcd[15:0];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_7_sec_counter.sv
// Elapsed-time counter for display_7: tick divider, 4-digit BCD count 0000..9999 with wrap,
// and a sticky stop flag that freezes the count once the game is lost.
module display_7_sec_counter #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lose,
    output logic [15:0] time_bcd
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              stop;
    logic [15:0]       time_next;
    logic              carry;

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    // Ripple-carry decimal increment; 9999 rolls over to 0000 on its own
    always_comb begin
        time_next = time_bcd;
        carry     = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (time_bcd[4*d +: 4] == 4'd9) begin
                    time_next[4*d +: 4] = 4'd0;
                end else begin
                    time_next[4*d +: 4] = time_bcd[4*d +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
            stop     <= 1'b0;
            time_bcd <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            if (lose) stop <= 1'b1;
            // A tick landing on the same edge as the first lose is discarded
            if (tick && !stop && !lose) time_bcd <= time_next;
        end
    end

endmodule

// File: rtl/display_7.sv
// Eight-digit multiplexed 7-segment driver: elapsed time on AN[7:4], grade on AN[3:0].
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zeros within each 4-digit field.
module display_7
    import display_7_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int SCAN_HZ = 1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lose,
    input  logic [15:0] grade,
    output logic [6:0]  oData,
    output logic [7:0]  AN
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_step;
    logic [2:0]        idx;
    logic [15:0]       time_bcd;
    logic [15:0]       grade_bcd;
    logic [15:0]       field;
    logic [3:0]        digit;
    logic              blank;
    logic [6:0]        seg_next;
    logic [7:0]        an_next;

    display_7_sec_counter #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_sec_counter (
        .clk      (clk),
        .rst      (rst),
        .lose     (lose),
        .time_bcd (time_bcd)
    );

    assign scan_step = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        grade_bcd = bin16_to_bcd4(grade);
        field     = idx[2] ? time_bcd : grade_bcd;
        digit     = field[{idx[1:0], 2'b00} +: 4];
`ifdef LEAD_ZERO_BLANK_EN
        // A digit is a leading zero when it and every more-significant digit of its field are zero
        case (idx[1:0])
            2'd3:    blank = (field[15:12] == 4'd0);
            2'd2:    blank = (field[15:8] == 8'd0);
            2'd1:    blank = (field[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        seg_next = blank ? SEG_BLANK : seg7(digit);
        an_next  = ~(8'd1 << idx);
    end

    // Anode and segments are both derived from the same idx sample, so they never disagree
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            AN       <= 8'hFF;
            oData    <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_step ? '0 : scan_cnt + SCAN_W'(1);
            if (scan_step) idx <= idx + 3'd1;
            AN    <= an_next;
            oData <= seg_next;
        end
    end

endmodule

// File: tb/tb_display_7.sv
// Randomized self-checking bench for display_7: two instances (slow and fast tick) compared
// every cycle against a decimal-arithmetic reference model of time, grade and scan position.
module tb_display_7;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  lose;
    logic [15:0] grade;
    logic [6:0]  od0, od1;
    logic [7:0]  an0, an1;

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance
    int k[2];
    int tval[2];
    int stopped[2];
    int tdiv[2] = '{10, 1};
    logic [6:0] segtab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    display_7 #(.CLK_HZ(100_000_000), .TICK_HZ(10_000_000), .SCAN_HZ(100_000_000)) dut0 (
        .clk(clk), .rst(rst_n[0]), .lose(lose[0]), .grade(grade), .oData(od0), .AN(an0));

    display_7 #(.CLK_HZ(100_000_000), .TICK_HZ(100_000_000), .SCAN_HZ(100_000_000)) dut1 (
        .clk(clk), .rst(rst_n[1]), .lose(lose[1]), .grade(grade), .oData(od1), .AN(an1));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pow10(input int p);
        int r = 1;
        for (int j = 0; j < p; j++) r = r * 10;
        return r;
    endfunction

    // Expected segments for scan position pos given current elapsed time and grade
    function automatic logic [6:0] exp_seg(input int pos, input int t, input int g);
        int v, p, d;
        logic [6:0] s;
        v = (pos >= 4) ? t : ((g > 9999) ? 9999 : g);
        p = pos % 4;
        d = (v / pow10(p)) % 10;
        s = segtab[d];
`ifdef LEAD_ZERO_BLANK_EN
        if (p > 0 && v < pow10(p)) s = 7'h7F;
`endif
        return s;
    endfunction

    task automatic cyc();
        logic [7:0] ea[2];
        logic [6:0] eo[2];
        logic [1:0] r_s, l_s;
        r_s = rst_n;
        l_s = lose;
        for (int i = 0; i < 2; i++) begin
            if (!r_s[i]) begin
                ea[i] = 8'hFF;
                eo[i] = 7'h7F;
            end else begin
                ea[i] = ~(8'd1 << (k[i] % 8));
                eo[i] = exp_seg(k[i] % 8, tval[i], int'(grade));
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!r_s[i]) begin
                k[i] = 0; tval[i] = 0; stopped[i] = 0;
            end else begin
                if (l_s[i]) stopped[i] = 1;
                else if (stopped[i] == 0 && ((k[i] + 1) % tdiv[i]) == 0)
                    tval[i] = (tval[i] + 1) % 10000;
                k[i]++;
            end
        end
        @(negedge clk);
        chk("an0", an0, ea[0]);
        chk("seg0", {1'b0, od0}, {1'b0, eo[0]});
        chk("an1", an1, ea[1]);
        chk("seg1", {1'b0, od1}, {1'b0, eo[1]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic reset_inst(input int i);
        rst_n[i] = 1'b0;
        run(2);
        rst_n[i] = 1'b1;
    endtask

    task automatic run_until_time(input int i, input int target, input int budget);
        bit hit = 0;
        for (int c = 0; c < budget; c++) begin
            if (tval[i] == target) begin
                hit = 1;
                break;
            end
            cyc();
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reach_time%0d: model time %0d expected %0d within budget", i, tval[i], target);
        end
    endtask

    initial begin
        rst_n = 2'b00;
        lose  = 2'b00;
        grade = 16'd0;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; tval[i] = 0; stopped[i] = 0;
        end

        // Reset, then the scan walk
        run(2);
        rst_n = 2'b11;
        run(16);

        grade = 16'd20;
        run(16);

        // Count to 25, pulse lose, time must stay frozen
        run_until_time(0, 25, 400);
        lose[0] = 1'b1;
        run(1);
        lose[0] = 1'b0;
        run(300);

        grade = 16'd55;
        run(16);
        reset_inst(0);
        run(24);

        grade = 16'hFFFF;
        run(16);

        // Fast-tick instance: reach 9999, wrap to 0000, freeze there
        reset_inst(1);
        run_until_time(1, 9999, 10100);
        run(1);
        lose[1] = 1'b1;
        run(1);
        lose[1] = 1'b0;
        run(16);

        // Small grade with time near zero exercises leading-digit handling
        reset_inst(0);
        grade = 16'd5;
        run(8);

        // Randomized grade, sporadic lose pulses and resets
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: grade = 16'($urandom_range(0, 9));
                1: grade = 16'($urandom_range(0, 999));
                2: grade = 16'($urandom_range(0, 9999));
                default: grade = 16'($urandom);
            endcase
            lose[0] = ($urandom_range(0, 199) == 0);
            rst_n[0] = ($urandom_range(0, 599) != 0);
            cyc();
        end
        rst_n = 2'b11;
        lose  = 2'b00;
        run(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
